// File: rtl/fpu_mailbox_host.sv
// Host-side mailbox driver: writes a 9-byte FPU request frame into shared RAM,
// waits for the engine, then reads back the 4-byte result and offers it on a valid/ready port.
module fpu_mailbox_host #(
  parameter int unsigned           addr_width  = 8,
  parameter logic [addr_width-1:0] OPD_BASE    = '0,
  parameter logic [addr_width-1:0] RES_BASE    = addr_width'(8'h1B),
  parameter int unsigned           WAIT_CYCLES = 260
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_a,
  input  logic [31:0]           req_b,
  input  logic [7:0]            req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_result,
  output logic                  busy,
  output logic [addr_width-1:0] addr,
  output logic [7:0]            data_out,
  input  logic [7:0]            data_in,
  output logic                  wen
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT,
    S_READ,
    S_RESP
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(WAIT_CYCLES - 1);

  state_t       state, state_next;
  logic [3:0]   cnt;
  logic [15:0]  wcnt;
  logic [71:0]  frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req_valid) state_next = S_WRITE;
      S_WRITE: if (cnt == 4'd8) state_next = (WAIT_CYCLES == 0) ? S_READ : S_WAIT;
      S_WAIT:  if (wcnt == WAIT_LAST) state_next = S_READ;
      S_READ:  if (cnt == 4'd4) state_next = S_RESP;
      S_RESP:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      wcnt       <= '0;
      frame      <= '0;
      addr       <= '0;
      data_out   <= '0;
      wen        <= 1'b0;
      rsp_result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            wen      <= 1'b1;
            addr     <= OPD_BASE;
            data_out <= req_a[31:24];
            // Remaining 8 bytes queued MSB-first; shifted out one per WRITE cycle.
            frame    <= {req_a[23:0], req_b, req_op, 8'h00};
            cnt      <= '0;
          end
        end
        S_WRITE: begin
          if (cnt == 4'd8) begin
            wen      <= 1'b0;
            addr     <= (WAIT_CYCLES == 0) ? RES_BASE : '0;
            data_out <= '0;
            cnt      <= '0;
            wcnt     <= '0;
          end else begin
            cnt      <= cnt + 4'd1;
            addr     <= addr + addr_width'(1);
            data_out <= frame[71:64];
            frame    <= {frame[63:0], 8'h00};
          end
        end
        S_WAIT: begin
          wcnt <= wcnt + 16'd1;
          if (wcnt == WAIT_LAST) begin
            addr <= RES_BASE;
            cnt  <= '0;
          end
        end
        S_READ: begin
          // RAM data lags the address by one cycle, so byte k-1 lands in read cycle k.
          if (cnt < 4'd3) addr <= addr + addr_width'(1);
          case (cnt)
            4'd1:    rsp_result[31:24] <= data_in;
            4'd2:    rsp_result[23:16] <= data_in;
            4'd3:    rsp_result[15:8]  <= data_in;
            4'd4:    rsp_result[7:0]   <= data_in;
            default: ;
          endcase
          cnt <= (cnt == 4'd4) ? 4'd0 : cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mailbox_host.sv
// Self-checking bench for fpu_mailbox_host: two instances (default timing, and zero-wait with
// a wrapping result base) against behavioural RAM and frame/result reference models.
module tb_fpu_mailbox_host;

  localparam int          WC [2] = '{0, 260};
  localparam logic [7:0]  RB [2] = '{8'hFE, 8'h1B};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic [7:0]  req_op [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_result [2];
  logic        busy [2];
  logic [7:0]  addr [2];
  logic [7:0]  data_out [2];
  logic [7:0]  data_in [2];
  logic        wen [2];

  logic [7:0]  ram [2][256];
  logic        pl_en [2];
  logic [7:0]  pl_addr [2];
  logic [7:0]  pl_data [2];
  logic [15:0] wlog [2][1024];
  int          wcount [2];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  fpu_mailbox_host #(.addr_width(8), .OPD_BASE(8'h00), .RES_BASE(8'hFE), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_a(req_a[0]), .req_b(req_b[0]), .req_op(req_op[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]), .busy(busy[0]), .addr(addr[0]),
    .data_out(data_out[0]), .data_in(data_in[0]), .wen(wen[0]));

  fpu_mailbox_host #(.addr_width(8), .OPD_BASE(8'h00), .RES_BASE(8'h1B), .WAIT_CYCLES(260)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_a(req_a[1]), .req_b(req_b[1]), .req_op(req_op[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]), .busy(busy[1]), .addr(addr[1]),
    .data_out(data_out[1]), .data_in(data_in[1]), .wen(wen[1]));

  initial begin
    wcount[0] = 0;
    wcount[1] = 0;
  end

  // Dual-port mailbox RAM model plus write logger.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pl_en[d]) ram[d][pl_addr[d]] <= pl_data[d];
      if (wen[d]) begin
        ram[d][addr[d]] <= data_out[d];
        wlog[d][wcount[d] % 1024] <= {addr[d], data_out[d]};
        wcount[d] <= wcount[d] + 1;
      end
      data_in[d] <= ram[d][addr[d]];
    end
  end

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      total_cnt++; if (req_ready[d] !== 1'b1) $display("FAIL reset_req_ready d%0d got %b exp 1", d, req_ready[d]); else pass_cnt++;
      total_cnt++; if (rsp_valid[d] !== 1'b0) $display("FAIL reset_rsp_valid d%0d got %b exp 0", d, rsp_valid[d]); else pass_cnt++;
      total_cnt++; if (wen[d] !== 1'b0) $display("FAIL reset_wen d%0d got %b exp 0", d, wen[d]); else pass_cnt++;
      total_cnt++; if (addr[d] !== 8'h00) $display("FAIL reset_addr d%0d got %h exp 00", d, addr[d]); else pass_cnt++;
      total_cnt++; if (data_out[d] !== 8'h00) $display("FAIL reset_data_out d%0d got %h exp 00", d, data_out[d]); else pass_cnt++;
      total_cnt++; if (busy[d] !== 1'b0) $display("FAIL reset_busy d%0d got %b exp 0", d, busy[d]); else pass_cnt++;
      total_cnt++; if (rsp_result[d] !== 32'h0) $display("FAIL reset_rsp_result d%0d got %h exp 0", d, rsp_result[d]); else pass_cnt++;
    end
  endtask

  task automatic preload(input int d, input logic [31:0] pre);
    for (int k = 0; k < 4; k++) begin
      pl_en[d]   = 1'b1;
      pl_addr[d] = RB[d] + 8'(k);
      pl_data[d] = pre[31-8*k -: 8];
      @(posedge clk); #1;
    end
    pl_en[d] = 1'b0;
  endtask

  // One full request: frame layout, write count, read addresses, latency, result, backpressure.
  task automatic run_txn(input int d, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] op, input logic [31:0] pre, input int stall);
    logic [71:0] fv;
    logic [31:0] exp_res;
    logic [7:0]  x;
    int          base;
    int          n;
    int          w;
    fv = {a, b, op};
    w  = WC[d];
    preload(d, pre);
    for (int k = 0; k < 4; k++) begin
      x = RB[d] + 8'(k);
      if (x <= 8'd8) exp_res[31-8*k -: 8] = fv[71-8*int'(x) -: 8];
      else           exp_res[31-8*k -: 8] = pre[31-8*k -: 8];
    end
    base = wcount[d];
    req_a[d] = a; req_b[d] = b; req_op[d] = op; req_valid[d] = 1'b1; rsp_ready[d] = 1'b0;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_a[d] = $urandom; req_b[d] = $urandom; req_op[d] = 8'($urandom);
    total_cnt++; if (busy[d] !== 1'b1 || req_ready[d] !== 1'b0)
      $display("FAIL accept_busy d%0d got busy=%b ready=%b exp 1/0", d, busy[d], req_ready[d]); else pass_cnt++;
    n = 0;
    while (rsp_valid[d] !== 1'b1 && n < 14 + w + 50) begin
      @(posedge clk); #1;
      n++;
      if (n >= 9 + w && n <= 12 + w) begin
        total_cnt++;
        if (addr[d] !== RB[d] + 8'(n - 9 - w))
          $display("FAIL read_addr d%0d cyc %0d got %h exp %h", d, n, addr[d], RB[d] + 8'(n - 9 - w));
        else pass_cnt++;
      end
    end
    total_cnt++; if (n != 14 + w) $display("FAIL latency d%0d got %0d exp %0d", d, n, 14 + w); else pass_cnt++;
    total_cnt++; if (wcount[d] - base != 9) $display("FAIL write_count d%0d got %0d exp 9", d, wcount[d] - base); else pass_cnt++;
    for (int k = 0; k < 9; k++) begin
      total_cnt++;
      if (wlog[d][(base + k) % 1024] !== {8'(k), fv[71-8*k -: 8]})
        $display("FAIL frame_byte d%0d k%0d got %h exp %h", d, k, wlog[d][(base + k) % 1024], {8'(k), fv[71-8*k -: 8]});
      else pass_cnt++;
    end
    total_cnt++; if (rsp_result[d] !== exp_res) $display("FAIL result d%0d got %h exp %h", d, rsp_result[d], exp_res); else pass_cnt++;
    for (int i = 0; i < stall; i++) begin
      req_valid[d] = 1'b1; req_a[d] = $urandom; req_b[d] = $urandom;
      @(posedge clk); #1;
      total_cnt++;
      if (rsp_valid[d] !== 1'b1 || rsp_result[d] !== exp_res || req_ready[d] !== 1'b0)
        $display("FAIL stall d%0d got valid=%b res=%h ready=%b exp 1/%h/0", d, rsp_valid[d], rsp_result[d], req_ready[d], exp_res);
      else pass_cnt++;
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    total_cnt++;
    if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1 || busy[d] !== 1'b0 || rsp_result[d] !== exp_res)
      $display("FAIL handshake d%0d got valid=%b ready=%b busy=%b res=%h exp 0/1/0/%h",
               d, rsp_valid[d], req_ready[d], busy[d], rsp_result[d], exp_res);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    run_txn(1, 32'h3F800000, 32'h40000000, 8'h01, 32'h40400000, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++)
      run_txn(1, $urandom, $urandom, 8'($urandom), $urandom, int'($urandom_range(0, 3)));
  endtask

  task automatic test_backpressure();
    run_txn(1, $urandom, $urandom, 8'($urandom), $urandom, 20);
  endtask

  task automatic test_reset_mid();
    req_a[1] = $urandom; req_b[1] = $urandom; req_op[1] = 8'($urandom); req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || wen[1] !== 1'b0 ||
        addr[1] !== 8'h00 || data_out[1] !== 8'h00 || busy[1] !== 1'b0)
      $display("FAIL mid_reset got ready=%b valid=%b wen=%b addr=%h dout=%h busy=%b exp 1/0/0/00/00/0",
               req_ready[1], rsp_valid[1], wen[1], addr[1], data_out[1], busy[1]);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(1, $urandom, $urandom, 8'($urandom), $urandom, 1);
  endtask

  task automatic test_zero_wait();
    run_txn(0, 32'h3F800000, 32'hC0A00000, 8'h02, 32'h11223344, 0);
    run_txn(0, $urandom, $urandom, 8'($urandom), $urandom, 2);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_a[d] = '0; req_b[d] = '0; req_op[d] = '0;
      rsp_ready[d] = 1'b0; pl_en[d] = 1'b0; pl_addr[d] = '0; pl_data[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_write_read();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_zero_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
